// File: rtl/admm_iter_sequencer_pkg.sv
// admm_iter_sequencer_pkg
//   Shared types and helpers for the ADMM iteration sequencer.
//   state_e  : controller states
//   idx_w    : index width for a count of n items (min 1 bit)
//   sat_abs  : saturating absolute value of a w-bit signed value (w <= 32),
//              passed sign-extended to 32 bits
package admm_iter_sequencer_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PRIMAL = 3'd1,
    SLACK  = 3'd2,
    DUAL   = 3'd3,
    RESID  = 3'd4,
    FINISH = 3'd5
  } state_e;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // The most negative w-bit value has no positive twin; it maps to the
  // largest positive value instead of wrapping back to itself.
  function automatic logic [31:0] sat_abs(input logic signed [31:0] x, input int w);
    logic signed [31:0] mn;
    mn = -(32'sd1 <<< (w - 1));
    if (x == mn) return ~mn;
    if (x < 0) return -x;
    return x;
  endfunction

endpackage

// File: rtl/admm_iter_sequencer_if.sv
// admm_iter_sequencer_if
//   Start/done handshake bundle between the sequencer and its stage engines
//   (primal solver, slack-update engine, dual-update engine).
//   master : sequencer side (drives *_start and knot_idx)
//   slave  : engine side    (drives *_done and the per-knot residuals)
interface admm_iter_sequencer_if #(
  parameter int HORIZON = 10,
  parameter int W       = 16
);
  localparam int KW = (HORIZON > 1) ? $clog2(HORIZON) : 1;

  logic                primal_start;
  logic                primal_done;
  logic                slack_start;
  logic                slack_done;
  logic                dual_start;
  logic                dual_done;
  logic signed [W-1:0] pri_res;
  logic signed [W-1:0] dual_res;
  logic [KW-1:0]       knot_idx;

  modport master (
    output primal_start, slack_start, dual_start, knot_idx,
    input  primal_done, slack_done, dual_done, pri_res, dual_res
  );

  modport slave (
    input  primal_start, slack_start, dual_start, knot_idx,
    output primal_done, slack_done, dual_done, pri_res, dual_res
  );
endinterface

// File: rtl/admm_iter_sequencer_tracker.sv
// admm_residual_tracker
//   Running maxima of the saturated |primal| and |dual| residuals over one
//   knot sweep, and the tolerance compare against the latched tolerances.
//   load_i      : latch tolerances and clear maxima (accepted start)
//   clr_i       : clear maxima (start of a new sweep)
//   upd_i       : fold pri_res_i / dual_res_i into the maxima
//   within_tol_o: both maxima <= their tolerances (unsigned, non-strict)
module admm_residual_tracker
  import admm_iter_sequencer_pkg::*;
#(
  parameter int W = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load_i,
  input  logic [W-1:0]        tol_pri_i,
  input  logic [W-1:0]        tol_dual_i,
  input  logic                clr_i,
  input  logic                upd_i,
  input  logic signed [W-1:0] pri_res_i,
  input  logic signed [W-1:0] dual_res_i,
  output logic                within_tol_o
);
  logic [W-1:0] tol_pri_q, tol_dual_q;
  logic [W-1:0] max_pri_q, max_dual_q;
  logic [W-1:0] pri_abs, dual_abs;

  assign pri_abs  = W'(sat_abs(32'(pri_res_i), W));
  assign dual_abs = W'(sat_abs(32'(dual_res_i), W));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tol_pri_q  <= '0;
      tol_dual_q <= '0;
      max_pri_q  <= '0;
      max_dual_q <= '0;
    end else begin
      if (load_i) begin
        tol_pri_q  <= tol_pri_i;
        tol_dual_q <= tol_dual_i;
      end
      if (load_i || clr_i) begin
        max_pri_q  <= '0;
        max_dual_q <= '0;
      end else if (upd_i) begin
        if (pri_abs > max_pri_q)   max_pri_q  <= pri_abs;
        if (dual_abs > max_dual_q) max_dual_q <= dual_abs;
      end
    end
  end

  assign within_tol_o = (max_pri_q <= tol_pri_q) && (max_dual_q <= tol_dual_q);
endmodule

// File: rtl/admm_iter_sequencer.sv
// admm_iter_sequencer
//   ADMM iteration controller: per iteration one primal solve, then a
//   slack/dual sweep over every horizon knot, then a residual check.
//   Stops on convergence, max_iter, abort or a stage watchdog timeout.
//   clk, reset            : clock, async active-high reset
//   start/abort           : solve control (start ignored while not IDLE)
//   max_iter/tol_pri/dual : sampled on an accepted start
//   eng                   : engine start/done handshakes, residuals, knot_idx
//   busy/done             : solve in progress / one-cycle completion pulse
//   converged/timed_out/iter_count : result, held until the next start
module admm_iter_sequencer
  import admm_iter_sequencer_pkg::*;
#(
  parameter int HORIZON = 10,
  parameter int W       = 16,
  parameter int ITER_W  = 8,
  parameter int TIMEOUT = 1024
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 abort,
  input  logic [ITER_W-1:0]    max_iter,
  input  logic [W-1:0]         tol_pri,
  input  logic [W-1:0]         tol_dual,
  admm_iter_sequencer_if.master eng,
  output logic                 busy,
  output logic                 done,
  output logic                 converged,
  output logic                 timed_out,
  output logic [ITER_W-1:0]    iter_count
);
  localparam int KW   = idx_w(HORIZON);
  localparam int WD_W = idx_w(TIMEOUT);

  state_e            state_q, state_d;
  logic              entry_q;
  logic [WD_W-1:0]   wd_q;
  logic [KW-1:0]     knot_q, knot_d;
  logic [ITER_W-1:0] iter_q, iter_d;
  logic [ITER_W-1:0] max_iter_q, max_iter_d;
  logic              conv_q, conv_d;
  logic              to_q, to_d;
  logic              trk_load, trk_clr, trk_upd, within_tol;
  logic              acc, wd_exp;

  // Done pulses are only honoured after the entry (start-pulse) cycle.
  assign acc    = !entry_q;
  assign wd_exp = (TIMEOUT != 0) && (wd_q == WD_W'(TIMEOUT - 1));

  admm_residual_tracker #(.W(W)) u_trk (
    .clk         (clk),
    .reset       (reset),
    .load_i      (trk_load),
    .tol_pri_i   (tol_pri),
    .tol_dual_i  (tol_dual),
    .clr_i       (trk_clr),
    .upd_i       (trk_upd),
    .pri_res_i   (eng.pri_res),
    .dual_res_i  (eng.dual_res),
    .within_tol_o(within_tol)
  );

  always_comb begin
    state_d    = state_q;
    knot_d     = knot_q;
    iter_d     = iter_q;
    max_iter_d = max_iter_q;
    conv_d     = conv_q;
    to_d       = to_q;
    trk_load   = 1'b0;
    trk_clr    = 1'b0;
    trk_upd    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          trk_load   = 1'b1;
          max_iter_d = max_iter;
          iter_d     = '0;
          conv_d     = 1'b0;
          to_d       = 1'b0;
          knot_d     = '0;
          state_d    = (max_iter == '0) ? FINISH : PRIMAL;
        end
      end
      PRIMAL: begin
        if (abort) state_d = FINISH;
        else if (acc && eng.primal_done) begin
          state_d = SLACK;
          knot_d  = '0;
          trk_clr = 1'b1;
        end else if (wd_exp) begin
          state_d = FINISH;
          to_d    = 1'b1;
        end
      end
      SLACK: begin
        if (abort) state_d = FINISH;
        else if (acc && eng.slack_done) state_d = DUAL;
        else if (wd_exp) begin
          state_d = FINISH;
          to_d    = 1'b1;
        end
      end
      DUAL: begin
        if (abort) state_d = FINISH;
        else if (acc && eng.dual_done) begin
          trk_upd = 1'b1;
          if (knot_q == KW'(HORIZON - 1)) state_d = RESID;
          else begin
            knot_d  = knot_q + KW'(1);
            state_d = SLACK;
          end
        end else if (wd_exp) begin
          state_d = FINISH;
          to_d    = 1'b1;
        end
      end
      RESID: begin
        // An abort here drops the iteration being checked.
        if (abort) state_d = FINISH;
        else begin
          iter_d  = iter_q + ITER_W'(1);
          conv_d  = within_tol;
          state_d = (within_tol || iter_d == max_iter_q) ? FINISH : PRIMAL;
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      entry_q    <= 1'b0;
      wd_q       <= '0;
      knot_q     <= '0;
      iter_q     <= '0;
      max_iter_q <= '0;
      conv_q     <= 1'b0;
      to_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      // Every stage entry is a state change, so this flags the first cycle
      // of a stage and restarts the watchdog there.
      entry_q    <= (state_d != state_q);
      wd_q       <= (state_d != state_q) ? '0 : wd_q + WD_W'(1);
      knot_q     <= knot_d;
      iter_q     <= iter_d;
      max_iter_q <= max_iter_d;
      conv_q     <= conv_d;
      to_q       <= to_d;
    end
  end

  assign eng.primal_start = (state_q == PRIMAL) && entry_q;
  assign eng.slack_start  = (state_q == SLACK)  && entry_q;
  assign eng.dual_start   = (state_q == DUAL)   && entry_q;
  assign eng.knot_idx     = knot_q;

  assign busy       = (state_q == PRIMAL) || (state_q == SLACK) ||
                      (state_q == DUAL)   || (state_q == RESID);
  assign done       = (state_q == FINISH);
  assign converged  = conv_q;
  assign timed_out  = to_q;
  assign iter_count = iter_q;
endmodule

// File: tb/tb_admm_iter_sequencer.sv
module tb_admm_iter_sequencer;
  localparam int H  = 3;
  localparam int W  = 16;
  localparam int IW = 8;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          reset, start, abort;
  logic [IW-1:0] max_iter;
  logic [W-1:0]  tol_pri, tol_dual;
  logic          busy, done, converged, timed_out;
  logic [IW-1:0] iter_count;

  admm_iter_sequencer_if #(.HORIZON(H), .W(W)) eng ();

  admm_iter_sequencer #(.HORIZON(H), .W(W), .ITER_W(IW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .max_iter(max_iter), .tol_pri(tol_pri), .tol_dual(tol_dual),
    .eng(eng),
    .busy(busy), .done(done), .converged(converged),
    .timed_out(timed_out), .iter_count(iter_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // ---------------- engine model / config ----------------
  int pri_tab [8][H];
  int dual_tab[8][H];
  bit rand_lat   = 0;
  bit stray_en   = 0;
  int withhold_it = -1, withhold_k = -1;
  int abort_it    = -1;
  int primal_cnt, slack_cnt, dual_cnt;
  int slack_knots[$];
  int dual_knots[$];
  int slack_cyc, abort_cyc, done_cyc;
  int pend, cnt, cur_it, cur_k;

  function automatic int lat();
    return rand_lat ? int'($urandom_range(4, 1)) : 1;
  endfunction

  initial begin
    eng.primal_done = 0; eng.slack_done = 0; eng.dual_done = 0;
    eng.pri_res = '0; eng.dual_res = '0; abort = 0;
    pend = 0; cnt = 0; cur_it = 0; cur_k = 0;
    forever begin
      @(negedge clk);
      eng.primal_done = 0; eng.slack_done = 0; eng.dual_done = 0; abort = 0;
      if (reset) begin
        pend = 0;
        continue;
      end
      if (pend != 0) begin
        cnt--;
        if (cnt == 0) begin
          case (pend)
            1: eng.primal_done = 1;
            2: eng.slack_done  = 1;
            default: begin
              eng.dual_done = 1;
              eng.pri_res   = W'(pri_tab[cur_it][cur_k]);
              eng.dual_res  = W'(dual_tab[cur_it][cur_k]);
              if (cur_it == abort_it && cur_k == 0) begin
                abort = 1;
                abort_cyc = cyc;
              end
            end
          endcase
          pend = 0;
        end
      end
      if (eng.primal_start) begin
        primal_cnt++;
        cur_it = (primal_cnt > 8) ? 7 : primal_cnt - 1;
        pend = 1; cnt = lat();
        if (stray_en && cur_it == 0) begin
          eng.primal_done = 1;   // inside the entry cycle
          eng.slack_done  = 1;   // wrong stage
          cnt = 3;
        end
      end
      if (eng.slack_start) begin
        slack_cnt++;
        cur_k = int'(eng.knot_idx);
        slack_knots.push_back(cur_k);
        slack_cyc = cyc;
        pend = (cur_it == withhold_it && cur_k == withhold_k) ? 0 : 2;
        cnt = lat();
      end
      if (eng.dual_start) begin
        dual_cnt++;
        dual_knots.push_back(int'(eng.knot_idx));
        pend = 3; cnt = lat();
      end
    end
  end

  // ---------------- reference model ----------------
  function automatic int sabs(input int x);
    int a;
    a = (x < 0) ? -x : x;
    return (a > 32767) ? 32767 : a;
  endfunction

  task automatic ref_model(input int mi, input int tp, input int td,
                           output int iters, output bit conv);
    int mp, md;
    iters = 0; conv = 0;
    for (int it = 0; it < mi; it++) begin
      mp = 0; md = 0;
      for (int k = 0; k < H; k++) begin
        if (sabs(pri_tab[it][k])  > mp) mp = sabs(pri_tab[it][k]);
        if (sabs(dual_tab[it][k]) > md) md = sabs(dual_tab[it][k]);
      end
      iters = it + 1;
      if (mp <= tp && md <= td) begin
        conv = 1;
        return;
      end
    end
  endtask

  task automatic fill(input int p, input int d);
    for (int i = 0; i < 8; i++)
      for (int k = 0; k < H; k++) begin
        pri_tab[i][k] = p; dual_tab[i][k] = d;
      end
  endtask

  // ---------------- solve driver ----------------
  int  rn;
  bit  rdone, rbusy;

  task automatic run_solve(input int mi, input int tp, input int td, input bit bs);
    primal_cnt = 0; slack_cnt = 0; dual_cnt = 0;
    slack_knots.delete(); dual_knots.delete();
    @(negedge clk);
    max_iter = IW'(mi); tol_pri = W'(tp); tol_dual = W'(td); start = 1;
    rn = 0; rdone = 0; rbusy = 0;
    while (rn < 3000 && !rdone) begin
      @(negedge clk);
      rn++;
      if (rn == 1) start = 0;
      if (bs && rn == 6) start = 1;
      if (bs && rn == 7) start = 0;
      if (done) begin
        rdone = 1; done_cyc = cyc; rbusy = busy;
      end
    end
    chk("done_seen", rdone, 1);
  endtask

  int  e_it;
  bit  e_cv;
  int  mi, tp, td, dpulses;

  initial begin
    reset = 1; start = 0; max_iter = '0; tol_pri = '0; tol_dual = '0;
    fill(0, 0);
    repeat (3) @(negedge clk);
    chk("reset_outs", {busy, done, converged, timed_out, iter_count, eng.knot_idx,
                       eng.primal_start, eng.slack_start, eng.dual_start}, 0);
    reset = 0;
    @(negedge clk);
    chk("idle_outs", {busy, done, converged, timed_out, iter_count}, 0);

    // 1: zero residuals, single-cycle engines, minimum latency
    fill(0, 0);
    run_solve(5, 0, 0, 0);
    chk("t1_latency", rn, 1 + 2 + 4*H + 1);
    chk("t1_busy_at_done", rbusy, 0);
    chk("t1_conv", converged, 1);
    chk("t1_iter", iter_count, 1);
    chk("t1_slack_knots", slack_knots.size() == 3 && slack_knots[0] == 0 &&
                          slack_knots[1] == 1 && slack_knots[2] == 2, 1);
    chk("t1_dual_knots", dual_knots.size() == 3 && dual_knots[0] == 0 &&
                         dual_knots[1] == 1 && dual_knots[2] == 2, 1);
    @(negedge clk);
    chk("t1_done_pulse", done, 0);
    chk("t1_conv_held", converged, 1);

    // 2: residual above tolerance at knot 2 -> runs to max_iter
    fill(0, 0);
    for (int i = 0; i < 8; i++) pri_tab[i][2] = 100;
    run_solve(4, 50, 0, 0);
    chk("t2_conv", converged, 0);
    chk("t2_iter", iter_count, 4);
    chk("t2_primal", primal_cnt, 4);

    // 3: saturating abs, and residual exactly equal to tolerance
    fill(0, 0);
    pri_tab[0][0] = -32768;
    run_solve(3, 32767, 0, 0);
    chk("t3_sat_conv", converged, 1);
    chk("t3_sat_iter", iter_count, 1);
    fill(0, 0);
    pri_tab[0][1] = 50; dual_tab[0][2] = -7;
    run_solve(3, 50, 7, 0);
    chk("t3_eq_conv", converged, 1);
    fill(0, 0);
    dual_tab[0][0] = -8;
    run_solve(1, 50, 7, 0);
    chk("t3_over_conv", converged, 0);
    chk("t3_over_iter", iter_count, 1);

    // randomized solves against the reference model
    rand_lat = 1;
    for (int s = 0; s < 10; s++) begin
      for (int i = 0; i < 8; i++)
        for (int k = 0; k < H; k++) begin
          pri_tab[i][k]  = ($urandom_range(3, 0) == 0) ? int'($urandom_range(800, 0)) - 400
                                                       : int'($urandom_range(80, 0)) - 40;
          dual_tab[i][k] = ($urandom_range(3, 0) == 0) ? int'($urandom_range(800, 0)) - 400
                                                       : int'($urandom_range(80, 0)) - 40;
        end
      if (s == 0) pri_tab[0][1] = -32768;
      mi = int'($urandom_range(6, 1));
      tp = int'($urandom_range(120, 0));
      td = int'($urandom_range(120, 0));
      ref_model(mi, tp, td, e_it, e_cv);
      run_solve(mi, tp, td, 0);
      chk("rnd_conv", converged, e_cv);
      chk("rnd_iter", iter_count, e_it);
      chk("rnd_to", timed_out, 0);
      chk("rnd_primal", primal_cnt, e_it);
      chk("rnd_slack", slack_cnt, e_it * H);
      chk("rnd_dual", dual_cnt, e_it * H);
    end
    rand_lat = 0;

    // 4: watchdog on a withheld slack_done at knot 1
    fill(0, 0);
    withhold_it = 0; withhold_k = 1;
    run_solve(5, 0, 0, 0);
    withhold_it = -1; withhold_k = -1;
    chk("t4_wd_delay", done_cyc - slack_cyc, TO);
    chk("t4_to", timed_out, 1);
    chk("t4_conv", converged, 0);
    chk("t4_knot", eng.knot_idx, 1);
    chk("t4_iter", iter_count, 0);

    // 5: abort together with dual_done in iteration 2; start while busy
    fill(100, 0);
    abort_it = 1;
    run_solve(5, 0, 0, 1);
    abort_it = -1;
    chk("t5_abort_lat", done_cyc - abort_cyc, 1);
    chk("t5_iter", iter_count, 1);
    chk("t5_conv", converged, 0);
    chk("t5_to", timed_out, 0);
    chk("t5_primal", primal_cnt, 2);
    chk("t5_slack", slack_cnt, H + 1);
    chk("t5_dual", dual_cnt, H + 1);
    repeat (4) @(negedge clk);
    chk("t5_quiet", {busy, primal_cnt}, 2);

    // 6a: stray slack_done in PRIMAL and primal_done in the entry cycle
    fill(0, 0);
    stray_en = 1;
    run_solve(5, 0, 0, 0);
    stray_en = 0;
    chk("t6_stray_latency", rn, 1 + 4 + 4*H + 1);
    chk("t6_stray_conv", converged, 1);
    chk("t6_stray_slack", slack_cnt, H);

    // 6b: max_iter = 0
    run_solve(0, 0, 0, 0);
    chk("t6_mi0_fast", rn <= 2, 1);
    chk("t6_mi0_iter", iter_count, 0);
    chk("t6_mi0_conv", converged, 0);
    chk("t6_mi0_primal", primal_cnt, 0);

    // 6c: reset in the middle of DUAL
    fill(100, 100);
    primal_cnt = 0; slack_cnt = 0; dual_cnt = 0;
    @(negedge clk);
    max_iter = 8'd5; tol_pri = '0; tol_dual = '0; start = 1;
    @(negedge clk);
    start = 0;
    for (int i = 0; i < 500 && dual_cnt < 2; i++) @(negedge clk);
    chk("t6_reached_dual", dual_cnt, 2);
    reset = 1;
    #1;
    chk("t6_rst_outs", {busy, done, converged, timed_out, iter_count, eng.knot_idx,
                        eng.primal_start, eng.slack_start, eng.dual_start}, 0);
    @(negedge clk);
    reset = 0;
    dpulses = 0;
    repeat (20) begin
      @(negedge clk);
      if (done || busy) dpulses++;
    end
    chk("t6_no_done", dpulses, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got 1, expected 0");
    $fatal(1, "simulation time limit");
  end
endmodule
